// File: rtl/sha_pkg.sv
// Shared SHA-256 message-schedule types, constants and sigma helpers.
// Used by the schedule front end and by its bench.
package sha_pkg;

  typedef logic [0:63][31:0] w64_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    EXPAND,
    OUT
  } sched_state_e;

  localparam logic [0:7][31:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ROTR(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return ROTR(x, 7) ^ ROTR(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return ROTR(x, 17) ^ ROTR(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_msg_sched.sv
// SHA-256 message front end: loads big-endian words, pads the message and
// expands each 512-bit block into W[0:63] for the compression pipe.
module sha_msg_sched
  import sha_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output w64_t        out_w,
  output logic        out_first,
  output logic        out_last
);

  sched_state_e state_q, state_d;
  w64_t         w_q, w_d;
  logic [4:0]   idx_q, idx_d;
  logic [5:0]   k_q, k_d;
  logic [63:0]  count_q, count_d;
  logic [4:0]   zero_from_q, zero_from_d;  // first word PAD clears
  logic [4:0]   pad_idx_q, pad_idx_d;      // word holding the 0x80 pad byte (16 = next block)
  logic         spill_q, spill_d;          // pad byte still to be written by PAD
  logic         len_pend_q, len_pend_d;
  logic         len_spill_q, len_spill_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         out_first_q, out_first_d;
  logic         out_last_q, out_last_d;

  logic [31:0]  keep_mask;
  logic [31:0]  pad_bits;

  always_comb begin
    keep_mask = 32'hffff_ffff;
    pad_bits  = 32'h0;
    case (in_bytes)
      3'd0: begin keep_mask = 32'h0000_0000; pad_bits = 32'h8000_0000; end
      3'd1: begin keep_mask = 32'hff00_0000; pad_bits = 32'h0080_0000; end
      3'd2: begin keep_mask = 32'hffff_0000; pad_bits = 32'h0000_8000; end
      3'd3: begin keep_mask = 32'hffff_ff00; pad_bits = 32'h0000_0080; end
      default: begin keep_mask = 32'hffff_ffff; pad_bits = 32'h0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    idx_d       = idx_q;
    k_d         = k_q;
    count_d     = count_q;
    zero_from_d = zero_from_q;
    pad_idx_d   = pad_idx_q;
    spill_d     = spill_q;
    len_pend_d  = len_pend_q;
    len_spill_d = len_spill_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: state_d = LOAD;

      LOAD: begin
        if (in_valid && in_ready_q) begin
          if (in_last) begin
            w_d[idx_q]  = (in_data & keep_mask) | pad_bits;
            count_d     = count_q + {58'd0, in_bytes, 3'd0};
            zero_from_d = idx_q + 5'd1;
            pad_idx_d   = idx_q + {4'd0, in_bytes[2]};
            spill_d     = in_bytes[2];
            state_d     = PAD;
          end else begin
            w_d[idx_q] = in_data;
            count_d    = count_q + 64'd32;
            idx_d      = idx_q + 5'd1;
            if (idx_q == 5'd15) begin
              k_d     = 6'd16;
              state_d = EXPAND;
            end
          end
        end
      end

      PAD: begin
        for (int j = 0; j < 16; j++) begin
          if (5'(j) >= zero_from_q) w_d[j] = 32'h0;
          if (spill_q && (5'(j) == pad_idx_q)) w_d[j] = 32'h8000_0000;
        end
        // Length only fits if the pad byte left W[14..15] free.
        if (pad_idx_q <= 5'd13) begin
          w_d[14]    = count_q[63:32];
          w_d[15]    = count_q[31:0];
          out_last_d = 1'b1;
        end else begin
          len_pend_d  = 1'b1;
          len_spill_d = (pad_idx_q == 5'd16);
          out_last_d  = 1'b0;
        end
        k_d     = 6'd16;
        state_d = EXPAND;
      end

      EXPAND: begin
        w_d[k_q] = sigma1(w_q[k_q - 6'd2]) + w_q[k_q - 6'd7]
                 + sigma0(w_q[k_q - 6'd15]) + w_q[k_q - 6'd16];
        k_d = k_q + 6'd1;
        if (k_q == 6'd63) state_d = OUT;
      end

      OUT: begin
        if (out_valid_q && out_ready) begin
          if (len_pend_q) begin
            len_pend_d  = 1'b0;
            zero_from_d = 5'd0;
            pad_idx_d   = 5'd0;
            spill_d     = len_spill_q;
            out_first_d = 1'b0;
            state_d     = PAD;
          end else if (out_last_q) begin
            count_d     = 64'd0;
            idx_d       = 5'd0;
            spill_d     = 1'b0;
            len_spill_d = 1'b0;
            out_first_d = 1'b1;
            out_last_d  = 1'b0;
            state_d     = LOAD;
          end else begin
            idx_d       = 5'd0;
            out_first_d = 1'b0;
            state_d     = LOAD;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      idx_q       <= 5'd0;
      k_q         <= 6'd0;
      count_q     <= 64'd0;
      zero_from_q <= 5'd0;
      pad_idx_q   <= 5'd0;
      spill_q     <= 1'b0;
      len_pend_q  <= 1'b0;
      len_spill_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b1;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      count_q     <= count_d;
      zero_from_q <= zero_from_d;
      pad_idx_q   <= pad_idx_d;
      spill_q     <= spill_d;
      len_pend_q  <= len_pend_d;
      len_spill_q <= len_spill_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_w     = w_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_sha_msg_sched.sv
// Directed bench for sha_msg_sched: padding cases, block flags, latency,
// output hold under back-pressure and mid-expansion reset.
module tb_sha_msg_sched;
  import sha_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic [2:0]  in_bytes = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  w64_t        out_w;
  logic        out_first;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  sha_msg_sched dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference expansion of a hand-built 16-word block.
  function automatic w64_t expand(input w64_t b);
    w64_t w = b;
    for (int k = 16; k < 64; k++)
      w[k] = sigma1(w[k-2]) + w[k-7] + sigma0(w[k-15]) + w[k-16];
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int n = 0;
    in_data = d; in_last = last; in_bytes = nb; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(input int lat, input string name);
    int n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid || (cyc - acc_cyc) != lat) begin
      errors++;
      $display("FAIL %s_latency got %0d (valid=%0b) want %0d", name, cyc - acc_cyc, out_valid, lat);
    end
    $display("block %s first=%0b last=%0b w0=%h w15=%h", name, out_first, out_last, out_w[0], out_w[15]);
  endtask

  task automatic check_block(input string name, input w64_t exp_w, input logic f, input logic l);
    checks++;
    if (out_w !== exp_w) begin
      errors++;
      for (int i = 0; i < 64; i++)
        if (out_w[i] !== exp_w[i]) begin
          $display("FAIL %s_sched W[%0d] got %h want %h", name, i, out_w[i], exp_w[i]);
          break;
        end
    end
    checks++;
    if (out_first !== f || out_last !== l) begin
      errors++;
      $display("FAIL %s_flags got first=%0b last=%0b want first=%0b last=%0b", name, out_first, out_last, f, l);
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL take_drop got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_first !== 1'b1 || out_last !== 1'b0 || out_w !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%0b vld=%0b first=%0b last=%0b w0=%h want 0 0 1 0 0",
               in_ready, out_valid, out_first, out_last, out_w[0]);
    end
  endtask

  task automatic test_abc();
    w64_t e = '0;
    int rel;
    do_reset();
    rel = cyc;
    send_word(32'h61626300, 1'b1, 3'd3);
    checks++;
    if (acc_cyc - rel != 2) begin
      errors++;
      $display("FAIL abc_first_accept got edge %0d want 2", acc_cyc - rel);
    end
    wait_out(49, "abc");
    checks++;
    if (out_w[0] !== 32'h61626380 || out_w[1:14] !== '0 || out_w[15] !== 32'h18) begin
      errors++;
      $display("FAIL abc_words got w0=%h w15=%h want 61626380 00000018", out_w[0], out_w[15]);
    end
    checks++;
    if (out_w[16] !== 32'h61626380 || out_w[17] !== 32'h000f0000 || out_w[18] !== 32'h7da86405) begin
      errors++;
      $display("FAIL abc_expand got %h %h %h want 61626380 000f0000 7da86405", out_w[16], out_w[17], out_w[18]);
    end
    e[0] = 32'h61626380; e[15] = 32'h18;
    check_block("abc", expand(e), 1'b1, 1'b1);
  endtask

  task automatic test_hold();
    w64_t snap = out_w;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_w !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d got vld=%0b rdy=%0b w0=%h want 1 0 %h", i, out_valid, in_ready, out_w[0], snap[0]);
      end
    end
    take();
  endtask

  task automatic test_vec2();
    w64_t e = '0;
    send_word(32'h87027900, 1'b1, 3'd3);
    wait_out(49, "vec2");
    e[0] = 32'h87027980; e[15] = 32'd24;
    check_block("vec2", expand(e), 1'b1, 1'b1);
    take();
  endtask

  task automatic test_empty();
    w64_t e = '0;
    send_word(32'hdeadbeef, 1'b1, 3'd0);
    wait_out(49, "empty");
    checks++;
    if (out_w[0] !== 32'h80000000 || out_w[15] !== 32'h0 || out_w[16] !== 32'h80000000) begin
      errors++;
      $display("FAIL empty_words got %h %h %h want 80000000 00000000 80000000", out_w[0], out_w[15], out_w[16]);
    end
    e[0] = 32'h80000000;
    check_block("empty", expand(e), 1'b1, 1'b1);
    take();
  endtask

  task automatic test_14words();
    w64_t e = '0;
    for (int i = 0; i < 14; i++) begin
      send_word(32'ha5000000 ^ 32'(i), i == 13, 3'd4);
      e[i] = 32'ha5000000 ^ 32'(i);
    end
    wait_out(49, "w14_b1");
    e[14] = 32'h80000000;
    check_block("w14_b1", expand(e), 1'b1, 1'b0);
    take();
    wait_out(49, "w14_b2");
    e = '0; e[15] = 32'd448;
    check_block("w14_b2", expand(e), 1'b0, 1'b1);
    take();
  endtask

  task automatic test_16words();
    w64_t e = '0;
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0) repeat (2) @(negedge clk);
      send_word(32'h3c000000 + 32'(i * 7), i == 15, 3'd4);
      e[i] = 32'h3c000000 + 32'(i * 7);
    end
    wait_out(49, "w16_b1");
    check_block("w16_b1", expand(e), 1'b1, 1'b0);
    take();
    wait_out(49, "w16_b2");
    e = '0; e[0] = 32'h80000000; e[15] = 32'd512;
    check_block("w16_b2", expand(e), 1'b0, 1'b1);
    take();
  endtask

  task automatic test_back_to_back();
    w64_t e = '0;
    for (int i = 0; i < 16; i++) begin
      send_word(32'h01020304 * 32'(i + 1), 1'b0, 3'd0);
      e[i] = 32'h01020304 * 32'(i + 1);
    end
    wait_out(48, "b2b_b1");
    check_block("b2b_b1", expand(e), 1'b1, 1'b0);
    take();
    out_ready = 1'b1;
    send_word(32'haabbccdd, 1'b1, 3'd2);
    wait_out(49, "b2b_b2");
    e = '0; e[0] = 32'haabb8000; e[15] = 32'd528;
    check_block("b2b_b2", expand(e), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_high got out_valid=%0b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    w64_t e = '0;
    send_word(32'h11223300, 1'b1, 3'd3);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_first !== 1'b1 || out_w !== '0) begin
      errors++;
      $display("FAIL midreset_state got vld=%0b rdy=%0b first=%0b w0=%h want 0 0 1 0", out_valid, in_ready, out_first, out_w[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    send_word(32'h61626300, 1'b1, 3'd3);
    wait_out(49, "midreset");
    e[0] = 32'h61626380; e[15] = 32'h18;
    check_block("midreset", expand(e), 1'b1, 1'b1);
    take();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_hold();
    test_vec2();
    test_empty();
    test_14words();
    test_16words();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_msg_sched.md
# sha_msg_sched

Message front end for the SHA-256 compression `Pipe`. It accepts a message as a stream of big-endian 32-bit words and applies SHA-256 padding (0x80 byte, zero fill, 64-bit bit length). It expands each 512-bit block into the 64-word schedule W[0:63] and presents it, with first/last block flags, to the consumer through a valid/ready handshake. It produces the `W` bus that `Pipe` consumes. The consumer uses `out_first` to load H0 and `out_last` to mark the final digest.

## Interface
- No parameters. Constants live in `sha_pkg`.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low (block held in reset while 0)
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  input word accepted on a rising edge where `in_valid & in_ready`
- `in_data`  in  32  message word, big-endian, first byte in [31:24]
- `in_last`  in  1  this is the final word of the message
- `in_bytes`  in  3  valid bytes in the final word, 0..4; ignored unless `in_last`; MSB-aligned
- `out_valid`  out  1  schedule block available
- `out_ready`  in  1  consumer takes the block on a rising edge where `out_valid & out_ready`
- `out_w`  out  64x32  packed [0:63][31:0] schedule W[0:63]
- `out_first`  out  1  block is the first of its message
- `out_last`  out  1  block is the last of its message

## Operation
- FSM states: IDLE, LOAD, PAD, EXPAND, OUT.
- Reset (async, `reset`=0) sets:
  - state IDLE, `in_ready`=0, `out_valid`=0
  - `out_w`=0, `out_first`=1, `out_last`=0
  - word index 0, 64-bit bit count 0, pending flags cleared
- IDLE -> LOAD after 1 cycle.
- LOAD: `in_ready`=1. Each accepted word is written to W[idx], idx increments, and bit count += 32.
- If idx reaches 16 on a non-last word: -> EXPAND.
- Final word (`in_last`):
  - Keep the top `in_bytes` bytes and place 0x80 at byte position `in_bytes`; lower bytes are 0.
  - Bit count += 8*`in_bytes`.
  - If `in_bytes`=4, the 0x80 goes in [31:24] of the following word. That word may be word 0 of the next block.
  - -> PAD.
- PAD (1 cycle): zero-fill the remaining words.
  - If the pad byte's word index is ≤13, W[14]=count[63:32] and W[15]=count[31:0]; the block is last.
  - Otherwise the block is not last, and "length block pending" is set. That next block is all zero plus the length, and carries 0x80000000 in W[0] if the pad byte spilled past W[15].
  - -> EXPAND.
- EXPAND: 48 cycles, one word per cycle, k=16..63.
  - W[k] = σ1(W[k-2]) + W[k-7] + σ0(W[k-15]) + W[k-16], mod 2^32.
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - -> OUT.
- OUT: `out_valid`=1. `out_w`, `out_first` and `out_last` are held stable until the handshake. On handshake:
  - if length block pending: -> PAD, with `out_first`=0
  - else if last: -> LOAD; count, idx and flags clear; `out_first`=1
  - else: -> LOAD, idx=0, `out_first`=0
- `in_ready`=0 outside LOAD, so input is back-pressured during PAD/EXPAND/OUT.
- Bit count wraps mod 2^64 (not reachable in practice).

## Timing
- All outputs are registered.
- The first word is accepted at the 2nd rising edge after `reset` rises: IDLE -> LOAD, then `in_ready`=1.
- Full non-last block: `out_valid` rises 48 edges after the edge accepting word 15.
- Final-word path: `out_valid` rises 49 edges after the edge accepting the last word (PAD + 48).
- Extra length block: `out_valid` rises 49 edges after the preceding OUT handshake.
- `in_valid` gaps stall LOAD without side effects.
- `out_ready` may be held high; the handshake completes on the first OUT edge.
- Reset mid-operation discards the partial block and count. Behaviour then matches power-up.

## Structure
- `sha_pkg` holds:
  - `ROTR`, `sigma0`, `sigma1` functions
  - H0 constant
  - `sched_state_e` enum
  - `w64_t` typedef (logic [0:63][31:0])
  - the testbench reuses the package functions
- No sub-module: the expander is one adder chain driven by a 6-bit k counter, in the same module.

## Test plan
- "abc": `in_data`=0x61626300, `in_last`=1, `in_bytes`=3
  - one block; W[0]=0x61626380, W[1..14]=0, W[15]=0x18, W[16]=0x61626380
  - `out_first`=`out_last`=1
  - `out_valid` 49 edges after acceptance
- `in_data`=0x87027900, `in_bytes`=3, last
  - W[0]=0x87027980, W[15]=24
  - `Pipe` fed `out_w` with H0 matches the golden digest
- Empty message: `in_bytes`=0, last
  - W[0]=0x80000000, W[15]=0, W[16]=0x80000000
- 14 full words, final `in_bytes`=4
  - block 1: W[14]=0x80000000, W[15]=0, `out_last`=0, `out_first`=1
  - block 2: W[0..14]=0, W[15]=448, `out_first`=0, `out_last`=1
- 16 full words, last on word 15
  - block 2: W[0]=0x80000000, W[15]=512
- `out_ready` held low 10 cycles: `out_w` stable and `in_ready`=0 throughout.
- Reset pulled low mid-EXPAND: `out_valid`=0 immediately; the next message yields `out_first`=1 and a correct schedule.
